// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   typedef logic [31:0] reg_t;
   typedef logic [63:0] dreg_t;

   localparam logic MD_MUL   = 1'b0;
   localparam logic MD_DIV   = 1'b1;
   localparam logic SIGNED   = 1'b0;
   localparam logic UNSIGNED = 1'b1;

   localparam reg_t ZERO_WORD = 32'h0000_0000;
   localparam reg_t ALL_ONES  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage (master) and muldiv (slave).
interface muldiv_if;
   import muldiv_pkg::*;

   logic  start_i;
   logic  mul_or_div_i;
   reg_t  dividend_i;
   reg_t  divisor_i;
   logic  reg1_signed0_unsigned1_i;
   logic  reg2_signed0_unsigned1_i;
   logic  flush_i;
   dreg_t result_o;
   logic  done_o;
   logic  busy_o;

   modport slave (
      input  start_i, mul_or_div_i, dividend_i, divisor_i,
      input  reg1_signed0_unsigned1_i, reg2_signed0_unsigned1_i, flush_i,
      output result_o, done_o, busy_o
   );

   modport master (
      output start_i, mul_or_div_i, dividend_i, divisor_i,
      output reg1_signed0_unsigned1_i, reg2_signed0_unsigned1_i, flush_i,
      input  result_o, done_o, busy_o
   );

endinterface

// File: rtl/muldiv.sv
// Radix-2 iterative multiply (shift-add) / divide (restoring) unit, 32 iterations,
// magnitude datapath with sign fix-up applied as the result is loaded.
module muldiv
   import muldiv_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  md
);

   function automatic dreg_t negate(input dreg_t v);
      return ~v + 64'd1;
   endfunction

   function automatic reg_t negate32(input reg_t v);
      dreg_t t;
      t = negate({ZERO_WORD, v});
      return t[31:0];
   endfunction

   md_state_e  state_q;
   logic [4:0] cnt_q;
   logic       op_q;
   logic       a_neg_q;
   logic       b_neg_q;
   dreg_t      prod_q;
   dreg_t      mcand_q;
   reg_t       mplier_q;
   reg_t       rem_q;
   reg_t       quo_q;
   reg_t       dvsr_q;
   dreg_t      result_q;
   logic       done_q;
   logic       busy_q;

   logic       a_neg;
   logic       b_neg;
   reg_t       a_abs;
   reg_t       b_abs;
   dreg_t      prod_d;
   logic [32:0] part_rem;
   logic       rem_ge;
   reg_t       rem_d;
   reg_t       quo_d;
   reg_t       quo_fix;
   reg_t       rem_fix;
   dreg_t      fix_d;

   assign a_neg = (md.reg1_signed0_unsigned1_i == SIGNED) && md.dividend_i[31];
   assign b_neg = (md.reg2_signed0_unsigned1_i == SIGNED) && md.divisor_i[31];
   assign a_abs = a_neg ? negate32(md.dividend_i) : md.dividend_i;
   assign b_abs = b_neg ? negate32(md.divisor_i)  : md.divisor_i;

   // One iteration of both datapaths; the 33-bit partial remainder keeps the shifted-out bit.
   always_comb begin
      prod_d   = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
      part_rem = {rem_q, quo_q[31]};
      rem_ge   = part_rem >= {1'b0, dvsr_q};
      rem_d    = rem_ge ? 32'(part_rem - {1'b0, dvsr_q}) : part_rem[31:0];
      quo_d    = {quo_q[30:0], rem_ge};
      quo_fix  = (a_neg_q ^ b_neg_q) ? negate32(quo_d) : quo_d;
      rem_fix  = a_neg_q ? negate32(rem_d) : rem_d;
      if (op_q == MD_MUL) begin
         fix_d = (a_neg_q ^ b_neg_q) ? negate(prod_d) : prod_d;
      end else begin
         fix_d = {quo_fix, rem_fix};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MD_IDLE;
         cnt_q    <= 5'd0;
         result_q <= 64'd0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            MD_IDLE: begin
               if (md.start_i && !md.flush_i) begin
                  op_q     <= md.mul_or_div_i;
                  a_neg_q  <= a_neg;
                  b_neg_q  <= b_neg;
                  cnt_q    <= 5'd0;
                  prod_q   <= 64'd0;
                  mcand_q  <= {ZERO_WORD, a_abs};
                  mplier_q <= b_abs;
                  rem_q    <= ZERO_WORD;
                  quo_q    <= a_abs;
                  dvsr_q   <= b_abs;
                  busy_q   <= 1'b1;
                  if (md.mul_or_div_i == MD_DIV && md.divisor_i == ZERO_WORD) begin
                     result_q <= {ALL_ONES, md.dividend_i};
                     done_q   <= 1'b1;
                     state_q  <= MD_DONE;
                  end else begin
                     state_q  <= MD_CALC;
                  end
               end
            end
            MD_CALC: begin
               if (md.flush_i) begin
                  state_q <= MD_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  prod_q   <= prod_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  rem_q    <= rem_d;
                  quo_q    <= quo_d;
                  cnt_q    <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) begin
                     result_q <= fix_d;
                     done_q   <= 1'b1;
                     state_q  <= MD_DONE;
                  end
               end
            end
            MD_DONE: begin
               state_q <= MD_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= MD_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign md.result_o = result_q;
   assign md.done_o   = done_q;
   assign md.busy_o   = busy_q;

endmodule
